// File: rtl/bit_reverse_buffer_if.sv
// Handshake bundle for the bit-reverse reorder stage: natural-order input
// stream, bit-reversed output stream and a drain status flag.
interface bit_reverse_buffer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG2N  = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic [LOG2N-1:0]  out_index;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  // Environment side: produces input samples, consumes reordered samples.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_index, out_valid, out_last, busy
  );

  // Reorder block side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_index, out_valid, out_last, busy
  );
endinterface

// File: rtl/bit_reverse_buffer.sv
// Single-frame reorder buffer ahead of the radix-2 butterflies. A frame is
// written at bit-reversed addresses during FILL and read back in address
// order during DRAIN, so out[k] = in[bitrev(k)].
module bit_reverse_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG2N  = 4
) (
  input logic                 clk,
  input logic                 rst,
  bit_reverse_buffer_if.slave bus_io
);
  localparam int unsigned      N       = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CntLast = LOG2N'(N - 1);

  typedef enum logic {StFill, StDrain} state_e;

  state_e            state_q, state_d;
  logic [LOG2N-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0]  rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] mem_q [N];

  logic              in_fire;
  logic              out_fire;
  logic              wr_en;
  logic [LOG2N-1:0]  wr_addr;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int j = 0; j < LOG2N; j++) begin
      r[j] = idx[LOG2N-1-j];
    end
    return r;
  endfunction

  // Handshake outputs derive only from state so in_ready/out_valid stay exclusive.
  always_comb begin
    bus_io.in_ready  = (state_q == StFill);
    bus_io.out_valid = (state_q == StDrain);
    bus_io.busy      = (state_q == StDrain);
    bus_io.out_data  = mem_q[rd_cnt_q];
    bus_io.out_index = rd_cnt_q;
    bus_io.out_last  = (state_q == StDrain) && (rd_cnt_q == CntLast);
  end

  // Next-state logic: counters wrap modulo N and each wrap flips the phase.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    in_fire  = bus_io.in_valid && (state_q == StFill);
    out_fire = bus_io.out_ready && (state_q == StDrain);
    // A sample offered while rst is high must not land in storage.
    wr_en    = in_fire && !rst;
    wr_addr  = bitrev(wr_cnt_q);

    unique case (state_q)
      StFill: begin
        if (in_fire) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == CntLast) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_fire) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == CntLast) begin
            state_d = StFill;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFill;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Frame storage; contents are not reset, a stale frame is never read out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= bus_io.in_data;
    end
  end
endmodule

// File: tb/tb_bit_reverse_buffer.sv
// Scoreboard bench for bit_reverse_buffer at LOG2N = 4, 3 and 1.
module tb_bit_reverse_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  exp_t q1[$];

  // Hand-computed bit-reversed read orders.
  int unsigned perm16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int unsigned perm8[8]   = '{0, 4, 2, 6, 1, 5, 3, 7};

  bit_reverse_buffer_if #(.DATA_W(16), .LOG2N(4)) if4 ();
  bit_reverse_buffer_if #(.DATA_W(16), .LOG2N(3)) if3 ();
  bit_reverse_buffer_if #(.DATA_W(16), .LOG2N(1)) if1 ();

  bit_reverse_buffer #(.DATA_W(16), .LOG2N(4)) dut4 (.clk(clk), .rst(rst), .bus_io(if4));
  bit_reverse_buffer #(.DATA_W(16), .LOG2N(3)) dut3 (.clk(clk), .rst(rst), .bus_io(if3));
  bit_reverse_buffer #(.DATA_W(16), .LOG2N(1)) dut1 (.clk(clk), .rst(rst), .bus_io(if1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitors: pop and compare on every output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && if4.out_valid) begin
      chk("n16_in_ready_low", 32'(if4.in_ready), 0);
      chk("n16_busy", 32'(if4.busy), 1);
      if (if4.out_ready) begin
        if (q4.size() == 0) begin
          chk("n16_unexpected_output", 32'(if4.out_data), 32'hdead);
        end else begin
          e = q4.pop_front();
          chk("n16_data", 32'(if4.out_data), 32'(e.d));
          chk("n16_index", 32'(if4.out_index), 32'(e.idx));
          chk("n16_last", 32'(if4.out_last), 32'(e.last));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && if3.out_valid && if3.out_ready) begin
      if (q3.size() == 0) begin
        chk("n8_unexpected_output", 32'(if3.out_data), 32'hdead);
      end else begin
        e = q3.pop_front();
        chk("n8_data", 32'(if3.out_data), 32'(e.d));
        chk("n8_index", 32'(if3.out_index), 32'(e.idx));
        chk("n8_last", 32'(if3.out_last), 32'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) begin
        chk("n2_unexpected_output", 32'(if1.out_data), 32'hdead);
      end else begin
        e = q1.pop_front();
        chk("n2_data", 32'(if1.out_data), 32'(e.d));
        chk("n2_index", 32'(if1.out_index), 32'(e.idx));
        chk("n2_last", 32'(if1.out_last), 32'(e.last));
      end
    end
  end

  task automatic exp16(input logic [15:0] base);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.d    = base + 16'(perm16[k]);
      e.idx  = 4'(k);
      e.last = (k == 15);
      q4.push_back(e);
    end
  endtask

  // Feed one 16-sample frame base..base+15; optional one-cycle gaps.
  task automatic fill16(input logic [15:0] base, input bit gaps);
    int t;
    for (int i = 0; i < 16; i++) begin
      t = 0;
      while (!if4.in_ready && t < 200) begin
        @(posedge clk); #1; t++;
      end
      if (t >= 200) chk("n16_in_ready_timeout", 0, 1);
      if4.in_valid = 1'b1;
      if4.in_data  = base + 16'(i);
      if (i == 15) chk("n16_no_valid_before_last_accept", 32'(if4.out_valid), 0);
      @(posedge clk); #1;
      if4.in_valid = 1'b0;
      if (gaps && i != 15) begin
        @(posedge clk); #1;
      end
    end
    chk("n16_first_valid_latency", 32'(if4.out_valid), 1);
  endtask

  task automatic wait_drained(input string name);
    int t;
    t = 0;
    while ((q4.size() != 0 || q3.size() != 0 || q1.size() != 0) && t < 300) begin
      @(posedge clk); #1; t++;
    end
    chk(name, 32'(q4.size() + q3.size() + q1.size()), 0);
  endtask

  initial begin
    int   t;
    exp_t e;
    rst = 1'b1;
    if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b1;
    if3.in_valid = 1'b0; if3.in_data = '0; if3.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_in_ready", 32'(if4.in_ready), 1);
    chk("reset_out_valid", 32'(if4.out_valid), 0);
    chk("reset_out_last", 32'(if4.out_last), 0);
    chk("reset_busy", 32'(if4.busy), 0);

    // Consecutive frame 0..15.
    exp16(16'd0);
    fill16(16'd0, 1'b0);
    wait_drained("drain_plain");

    // Gapped input and a 3-cycle stall at index 5.
    exp16(16'd0);
    fill16(16'd0, 1'b1);
    t = 0;
    while (!(if4.out_valid && if4.out_index == 4'd5) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("stall_reach_index5", 32'(t < 200), 1);
    if4.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_data_hold", 32'(if4.out_data), 32'd10);
      chk("stall_index_hold", 32'(if4.out_index), 32'd5);
      @(posedge clk);
    end
    #1 if4.out_ready = 1'b1;
    wait_drained("drain_stall");

    // Junk offered during drain must be ignored.
    exp16(16'd200);
    fill16(16'd200, 1'b0);
    if4.in_valid = 1'b1;
    if4.in_data  = 16'hFFFF;
    t = 0;
    while (!if4.in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if4.in_valid = 1'b0;
    chk("junk_drain_ends", 32'(t < 200), 1);
    exp16(16'd300);
    fill16(16'd300, 1'b0);
    wait_drained("drain_after_junk");

    // Reset mid-frame discards the partial frame and the reset-cycle sample.
    for (int i = 0; i < 7; i++) begin
      if4.in_valid = 1'b1;
      if4.in_data  = 16'(50 + i);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    if4.in_data = 16'h00AA;
    @(posedge clk); #1;
    rst = 1'b0;
    if4.in_valid = 1'b0;
    chk("midreset_out_valid", 32'(if4.out_valid), 0);
    chk("midreset_busy", 32'(if4.busy), 0);
    chk("midreset_in_ready", 32'(if4.in_ready), 1);
    exp16(16'd100);
    fill16(16'd100, 1'b0);
    wait_drained("drain_after_reset");

    // Back-to-back frames; in_ready returns one cycle after the last transfer.
    exp16(16'd0);
    fill16(16'd0, 1'b0);
    t = 0;
    while (!(if4.out_valid && if4.out_last) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("b2b_in_ready_at_last", 32'(if4.in_ready), 0);
    @(posedge clk); #1;
    chk("b2b_in_ready_after_last", 32'(if4.in_ready), 1);
    exp16(16'd16);
    fill16(16'd16, 1'b0);
    wait_drained("drain_b2b");

    // Small frame sizes: N = 8 and N = 2.
    for (int k = 0; k < 8; k++) begin
      e.d = 16'(perm8[k]); e.idx = 4'(k); e.last = (k == 7);
      q3.push_back(e);
    end
    e.d = 16'hA5A5; e.idx = 4'd0; e.last = 1'b0; q1.push_back(e);
    e.d = 16'h5A5A; e.idx = 4'd1; e.last = 1'b1; q1.push_back(e);
    for (int i = 0; i < 8; i++) begin
      if3.in_valid = 1'b1;
      if3.in_data  = 16'(i);
      if (i < 2) begin
        if1.in_valid = 1'b1;
        if1.in_data  = (i == 0) ? 16'hA5A5 : 16'h5A5A;
      end else begin
        if1.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i == 1) chk("n2_first_valid_latency", 32'(if1.out_valid), 1);
    end
    if3.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    chk("n8_first_valid_latency", 32'(if3.out_valid), 1);
    wait_drained("drain_small");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bit_reverse_buffer.md
Name: bit_reverse_buffer

Overview:
- Input reorder stage ahead of the radix-2 FFT butterfly pipeline.
- Accepts one frame of N = 2^LOG2N samples in natural order and stores each at the bit-reversed address of its arrival index.
- Then streams the frame out in address order, so the butterfly stage receives out[k] = in[bitrev(k)].
- Single frame buffer: fill phase and drain phase alternate, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 16, sample width in bits (packed complex or real; opaque to this block).
- LOG2N, 4, log2 of frame length; N = 2^LOG2N; legal range 1..10.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  sample in natural order.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a sample this cycle.
- out_data  output  DATA_W  reordered sample.
- out_index  output  LOG2N  output position k, 0..N-1.
- out_valid  output  1  out_data/out_index are valid.
- out_ready  input  1  downstream accepts the sample this cycle.
- out_last  output  1  high with out_valid when out_index == N-1.
- busy  output  1  high in DRAIN.

Behaviour:
- Storage: N x DATA_W register array, no reset on contents. Counters: wr_cnt and rd_cnt, each LOG2N bits.
- bitrev(i): bit j of the result = bit (LOG2N-1-j) of i.
- States: FILL and DRAIN.
- Reset (synchronous, rst high at clock edge):
  - state = FILL, wr_cnt = 0, rd_cnt = 0.
  - out_valid = 0, out_last = 0, busy = 0, in_ready = 1 from the next cycle.
  - Reset mid-frame discards the partial frame. Any sample offered in the reset cycle is not accepted.
- FILL:
  - in_ready = 1, out_valid = 0.
  - Accept occurs on in_valid && in_ready: mem[bitrev(wr_cnt)] <= in_data, wr_cnt <= wr_cnt + 1.
  - in_valid gaps are allowed; wr_cnt holds during a gap.
  - On the accept with wr_cnt == N-1: wr_cnt wraps to 0 and state -> DRAIN.
- DRAIN:
  - in_ready = 0; in_valid is ignored and no write occurs.
  - out_valid = 1, busy = 1.
  - out_data = mem[rd_cnt] (combinational read of registered storage), out_index = rd_cnt, out_last = (rd_cnt == N-1).
  - Transfer occurs on out_valid && out_ready: rd_cnt <= rd_cnt + 1.
  - Backpressure (out_ready = 0): out_data, out_index and out_last hold stable.
  - Transfer with rd_cnt == N-1: rd_cnt wraps to 0, state -> FILL, in_ready = 1 the following cycle.
- Latency:
  - First out_valid is asserted the cycle after the final input accept.
  - Minimum frame period is 2N cycles (N fill + N drain), with no overlap between frames.
- Width rules: data passes through unmodified with no arithmetic. Counters wrap modulo N.
- in_ready and out_valid are never high in the same cycle.

Test Plan:
- Reset, then LOG2N=4, in_data = 0..15 on consecutive cycles with out_ready=1 -> out_data sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_index 0..15; out_last only on the 16th output; first out_valid 1 cycle after the 16th accept.
- Same frame with in_valid toggled 1,0,1,0… and out_ready low for 3 cycles at out_index=5 -> identical output order; out_data=10 and out_index=5 held stable for all stalled cycles; no output lost or duplicated.
- During DRAIN drive in_valid=1 with in_data=16'hFFFF -> in_ready=0 throughout; drained values unchanged; the next frame fills from wr_cnt=0.
- Load 7 samples, assert rst for 1 cycle, then feed 16 samples 100..115 -> outputs 100,108,104,112,… (the first 7 discarded); out_valid=0 and busy=0 from the cycle after reset.
- Two back-to-back frames (0..15, then 16..31) -> second drain yields 16,24,20,28,…; in_ready reasserts exactly 1 cycle after the first frame's out_last transfer.
- LOG2N=1, inputs A,B -> outputs A,B; LOG2N=3, inputs 0..7 -> outputs 0,4,2,6,1,5,3,7.
